// File: rtl/box_drawer_pkg.sv
// Shared widths, screen defaults, FSM state type and the extent-clipping
// helper for the box_drawer rectangle rasteriser.
package box_drawer_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam int unsigned SCREEN_W_DEFAULT = 160;
  localparam int unsigned SCREEN_H_DEFAULT = 120;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } box_state_t;

  // Visible extent of a span starting at origin with the given size inside
  // [0, limit). Done at 9 bits so origin+size can never wrap.
  function automatic logic [8:0] clip_extent(input logic [8:0] origin,
                                             input logic [8:0] size,
                                             input logic [8:0] limit);
    logic [8:0] room;
    room = limit - origin;
    if (origin >= limit) return '0;
    if (size > room) return room;
    return size;
  endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Nested column/row scan counter: column runs fastest, wraps to 0 and bumps
// the row. `last` flags the final position of a w_eff x h_eff scan.
module xy_scan_counter
  import box_drawer_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] w_eff,
  input  logic [Y_W-1:0] h_eff,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last
);

  logic col_end;
  logic row_end;

  // End-of-row / end-of-scan decode for the current position
  always_comb begin
    col_end = (col == w_eff - X_W'(1));
    row_end = (row == h_eff - Y_W'(1));
    last    = col_end && row_end;
  end

  // Position register: cleared on load, stepped in raster order on advance
  always_ff @(posedge clock) begin
    if (reset || load) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/box_drawer.sv
// Rectangle rasteriser feeding the VGA adapter pixel-write port: latches one
// command, clips it to the framebuffer and emits one pixel per clock.
// Optional feature macro: BOX_DRAWER_OUTLINE_EN (adds `outline` input; when
// set, only the border pixels of the rectangle are plotted).
module box_drawer
  import box_drawer_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
  parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour_in,
`ifdef BOX_DRAWER_OUTLINE_EN
  input  logic                outline,
`endif
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  box_state_t state, state_d;

  logic [X_W-1:0]      x0_l;
  logic [Y_W-1:0]      y0_l;
  logic [X_W-1:0]      w_eff_l;
  logic [Y_W-1:0]      h_eff_l;
  logic [COLOUR_W-1:0] colour_l;

  logic [8:0] w_clip;
  logic [8:0] h_clip;
  logic       area_nz;

  logic           load;
  logic           advance;
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;
  logic           last;
  logic           col_end;
  logic [X_W-1:0] nxt_col;
  logic [Y_W-1:0] nxt_row;
  logic           nxt_plot;

  logic [X_W-1:0]      x_d;
  logic [Y_W-1:0]      y_d;
  logic [COLOUR_W-1:0] colour_d;
  logic                plot_d;
  logic                busy_d;
  logic                done_d;

  xy_scan_counter u_scan (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .w_eff   (w_eff_l),
    .h_eff   (h_eff_l),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  // Clip the incoming command against the framebuffer
  always_comb begin
    w_clip  = clip_extent({1'b0, x0}, {1'b0, w}, 9'(SCREEN_W));
    h_clip  = clip_extent({2'b0, y0}, {2'b0, h}, 9'(SCREEN_H));
    area_nz = (w_clip != '0) && (h_clip != '0);
  end

  // Scan position one step ahead, so the registered outputs line up with
  // the counter position they describe
  always_comb begin
    col_end = (col == w_eff_l - X_W'(1));
    nxt_col = col_end ? '0 : col + X_W'(1);
    nxt_row = col_end ? row + Y_W'(1) : row;
  end

`ifdef BOX_DRAWER_OUTLINE_EN
  logic outline_l;

  // Outline decode: interior positions are visited but not plotted
  always_comb begin
    nxt_plot = !outline_l ||
               (nxt_col == '0) || (nxt_col == w_eff_l - X_W'(1)) ||
               (nxt_row == '0) || (nxt_row == h_eff_l - Y_W'(1));
  end

  // Outline flag is captured with the rest of the command
  always_ff @(posedge clock) begin
    if (!reset && load) outline_l <= outline;
  end
`else
  // Filled rectangles only: every visited position is plotted
  always_comb begin
    nxt_plot = 1'b1;
  end
`endif

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and next-output decode. The origin pixel is always on the
  // border, so it is plotted unconditionally on acceptance.
  always_comb begin
    state_d  = state;
    x_d      = x;
    y_d      = y;
    colour_d = '0;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          busy_d = 1'b1;
          if (area_nz) begin
            state_d  = DRAW;
            x_d      = x0;
            y_d      = y0;
            colour_d = colour_in;
            plot_d   = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DRAW: begin
        busy_d = 1'b1;
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          advance  = 1'b1;
          x_d      = x0_l + nxt_col;
          y_d      = y0_l + nxt_row;
          colour_d = colour_l;
          plot_d   = nxt_plot;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Command latch: origin, colour and clipped extents held for the scan
  always_ff @(posedge clock) begin
    if (!reset && load) begin
      x0_l     <= x0;
      y0_l     <= y0;
      colour_l <= colour_in;
      w_eff_l  <= X_W'(w_clip);
      h_eff_l  <= Y_W'(h_clip);
    end
  end

  // Registered outputs to the adapter
  always_ff @(posedge clock) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
// Self-checking bench for box_drawer: per-cycle output traces compared
// against a reference built from the rectangle/clipping rules.
// Outline scenario is included when BOX_DRAWER_OUTLINE_EN is defined.
module tb_box_drawer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [7:0] w;
  logic [6:0] h;
  logic [2:0] colour_in;
`ifdef BOX_DRAWER_OUTLINE_EN
  logic       outline;
`endif
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  logic outline_sel = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       draw;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       done;
  } trace_t;

  trace_t obs_q[$];
  trace_t exp_q[$];

  box_drawer #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
`ifdef BOX_DRAWER_OUTLINE_EN
    .outline   (outline),
`endif
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  function automatic int unsigned clip(input int unsigned o, input int unsigned s,
                                       input int unsigned lim);
    if (o >= lim) return 0;
    return (s < lim - o) ? s : lim - o;
  endfunction

  function automatic trace_t idle_entry();
    trace_t t;
    t.draw = 0; t.plot = 0; t.x = '0; t.y = '0; t.colour = '0;
    t.busy = 0; t.done = 0;
    return t;
  endfunction

  // Comparable view of a trace entry; x/y only matter on scan cycles
  function automatic logic [20:0] pk(input trace_t t, input logic draw);
    return {t.plot, t.busy, t.done, t.colour, draw ? t.x : 8'd0, draw ? t.y : 7'd0};
  endfunction

  // Reference: raster scan of the clipped rectangle, a done cycle, idle tail
  task automatic build_expected(input int unsigned ox, input int unsigned oy,
                                input int unsigned cw, input int unsigned ch,
                                input int unsigned cc, input int unsigned tail);
    int unsigned we, he;
    trace_t t;
    we = clip(ox, cw, 160);
    he = clip(oy, ch, 120);
    exp_q.delete();
    for (int unsigned k = 0; k < we * he; k++) begin
      int unsigned c, r;
      c = k % we;
      r = k / we;
      t.draw   = 1;
      t.x      = 8'(ox + c);
      t.y      = 7'(oy + r);
      t.colour = 3'(cc);
      t.plot   = !outline_sel || c == 0 || c == we - 1 || r == 0 || r == he - 1;
      t.busy   = 1;
      t.done   = 0;
      exp_q.push_back(t);
    end
    t = idle_entry();
    t.busy = 1;
    t.done = 1;
    exp_q.push_back(t);
    for (int unsigned k = 0; k < tail; k++) exp_q.push_back(idle_entry());
  endtask

  // Issue a command (caller is at a negedge) and record n output cycles.
  // Optional mid-command start injection and reset assertion.
  task automatic capture(input logic [7:0] cx0, input logic [6:0] cy0,
                         input logic [7:0] cw, input logic [6:0] ch,
                         input logic [2:0] cc, input int n,
                         input int inj_cycle, input int rst_cycle);
    trace_t t;
    obs_q.delete();
    x0 = cx0; y0 = cy0; w = cw; h = ch; colour_in = cc; start = 1'b1;
`ifdef BOX_DRAWER_OUTLINE_EN
    outline = outline_sel;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      t.draw = 0; t.plot = plot; t.x = x; t.y = y; t.colour = colour;
      t.busy = busy; t.done = done;
      obs_q.push_back(t);
      if (i == 0) begin
        start = 1'b0;
        x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom);
        h = 7'($urandom); colour_in = 3'($urandom);
`ifdef BOX_DRAWER_OUTLINE_EN
        outline = 1'($urandom);
`endif
      end
      if (i == inj_cycle) begin
        start = 1'b1;
        x0 = 8'd1; y0 = 7'd2; w = 8'd1; h = 7'd1; colour_in = ~cc;
      end
      if (i == inj_cycle + 1) start = 1'b0;
      if (i == rst_cycle) reset = 1'b1;
      if (i == rst_cycle + 1) reset = 1'b0;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
`ifdef BOX_DRAWER_OUTLINE_EN
    outline = 1'b0;
`endif
    repeat (3) @(negedge clock);
    checks++;
    if ({x, y, colour, plot, busy, done} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b want all 0",
               x, y, colour, plot, busy, done);
    end
    // reset and start together: command must be dropped
    x0 = 8'd10; y0 = 7'd10; w = 8'd4; h = 7'd4; colour_in = 3'd7; start = 1'b1;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({plot, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL reset_with_start[%0d] got plot=%b busy=%b done=%b want 000",
                 i, plot, busy, done);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_box_2x2();
    @(negedge clock);
    build_expected(10, 5, 2, 2, 3'b100, 1);
    capture(8'd10, 7'd5, 8'd2, 7'd2, 3'b100, exp_q.size(), -10, -10);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL box_2x2[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
  endtask

  task automatic test_clip();
    @(negedge clock);
    build_expected(158, 119, 5, 3, 3'b011, 1);
    capture(8'd158, 7'd119, 8'd5, 7'd3, 3'b011, exp_q.size(), -10, -10);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL clip[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
  endtask

  task automatic test_zero_size();
    @(negedge clock);
    build_expected(30, 40, 0, 4, 3'b111, 2);
    capture(8'd30, 7'd40, 8'd0, 7'd4, 3'b111, exp_q.size(), -10, -10);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL zero_size[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clock);
    build_expected(50, 60, 4, 3, 3'b010, 2);
    capture(8'd50, 7'd60, 8'd4, 7'd3, 3'b010, exp_q.size(), 2, -10);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL start_ignored[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    build_expected(70, 30, 4, 4, 3'b101, 0);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    repeat (3) exp_q.push_back(idle_entry());
    capture(8'd70, 7'd30, 8'd4, 7'd4, 3'b101, exp_q.size(), -10, 2);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
    // the next command after the abort draws normally
    build_expected(3, 4, 3, 2, 3'b110, 1);
    capture(8'd3, 7'd4, 8'd3, 7'd2, 3'b110, exp_q.size(), -10, -10);
    foreach (exp_q[i]) begin
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL after_reset[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
  endtask

  // Random commands issued back to back: each start lands in the idle
  // cycle immediately following the previous done
  task automatic test_back_to_back();
    @(negedge clock);
    for (int n = 0; n < 25; n++) begin
      int unsigned rx, ry, rw, rh, rc;
      rx = $urandom_range(0, 175);
      ry = $urandom_range(0, 127);
      rw = $urandom_range(0, 14);
      rh = $urandom_range(0, 9);
      rc = $urandom_range(0, 7);
      build_expected(rx, ry, rw, rh, rc, 1);
      capture(8'(rx), 7'(ry), 8'(rw), 7'(rh), 3'(rc), exp_q.size(), -10, -10);
      foreach (exp_q[i]) begin
        checks++;
        if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
          errors++;
          $display("FAIL random%0d(%0d,%0d,%0dx%0d)[%0d] got=%h want=%h", n,
                   rx, ry, rw, rh, i,
                   pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
        end
      end
    end
  endtask

`ifdef BOX_DRAWER_OUTLINE_EN
  task automatic test_outline();
    int plots;
    @(negedge clock);
    outline_sel = 1'b1;
    build_expected(20, 20, 3, 3, 3'b001, 1);
    capture(8'd20, 7'd20, 8'd3, 7'd3, 3'b001, exp_q.size(), -10, -10);
    plots = 0;
    foreach (exp_q[i]) begin
      if (obs_q[i].plot === 1'b1) plots++;
      checks++;
      if (pk(obs_q[i], exp_q[i].draw) !== pk(exp_q[i], exp_q[i].draw)) begin
        errors++;
        $display("FAIL outline[%0d] got=%h want=%h", i,
                 pk(obs_q[i], exp_q[i].draw), pk(exp_q[i], exp_q[i].draw));
      end
    end
    checks++;
    if (plots != 8) begin
      errors++;
      $display("FAIL outline_plot_count got %0d want 8", plots);
    end
    outline_sel = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_box_2x2();
    test_clip();
    test_zero_size();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef BOX_DRAWER_OUTLINE_EN
    test_outline();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
